csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 Parameter XLEN, default 32, is the data width of every CSR and data port.
REQ-002 Parameter NUM_CSR, default 8, range 1..16, is the number of read/write scratch CSRs.
REQ-003 Parameter BASE_ADDR, default 12'h340, is the address of scratch CSR 0; scratch CSR i is at BASE_ADDR+i.
REQ-004 Parameter CNT_EN, default 1, includes the read-only cycle (12'hC00) and instret (12'hC02) counters when 1.
REQ-005 Port clk, input, 1: single system clock, rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port halt, input, 1: pipeline halt; freezes the FSM and the cycle counter.
REQ-008 Port req_valid, input, 1: CSR instruction request.
REQ-009 Port req_ready, output, 1: block can accept a request.
REQ-010 Port funct3, input, 3: CSR operation encoding.
REQ-011 Port csr_addr, input, 12: target CSR address.
REQ-012 Port src_idx, input, 5: rs1 index for register forms, or uimm for immediate forms.
REQ-013 Port rs1_data, input, XLEN: register operand.
REQ-014 Port instr_retire, input, 1: one instruction retired this cycle.
REQ-015 Port rsp_valid, output, 1: one-cycle response strobe.
REQ-016 Port rsp_rdata, output, XLEN: CSR value before modification, for write-back to rd.
REQ-017 Port rsp_illegal, output, 1: illegal access; valid with rsp_valid.

Function
REQ-018 The FSM SHALL have three states: IDLE, READ and WRITE; req_ready SHALL be 1 only in IDLE with halt=0.
REQ-019 In IDLE, a cycle with req_valid=1 and req_ready=1 SHALL latch funct3, csr_addr, src_idx and rs1_data, and move to READ.
REQ-020 READ SHALL capture the old CSR value and compute the new value, then move to WRITE.
REQ-021 WRITE SHALL perform the write if it is enabled, assert rsp_valid for exactly one cycle, and return to IDLE.
REQ-022 rsp_valid SHALL rise exactly 2 cycles after the accept edge when halt=0.
REQ-023 When halt=1 in READ or WRITE, the FSM SHALL hold its state, perform no write and keep rsp_valid=0; it SHALL resume when halt returns to 0.
REQ-024 The operand SHALL be rs1_data for funct3 001/010/011, and {XLEN-5 zeros, src_idx} for funct3 101/110/111.
REQ-025 The new value SHALL be: RW/RWI = operand; RS/RSI = old | operand; RC/RCI = old & ~operand.
REQ-026 The write SHALL be suppressed, while the read still occurs, for RS/RC/RSI/RCI when src_idx=0; RW/RWI SHALL always write.
REQ-027 The access SHALL be illegal for any of:
- funct3 = 000 or 100;
- an unimplemented address;
- an enabled write to an address with csr_addr[11:10]=2'b11.
REQ-028 An illegal access SHALL perform no write, return rsp_rdata=0 and set rsp_illegal=1.
REQ-029 A read of an implemented read-only counter with the write suppressed SHALL be legal.
REQ-030 The cycle counter SHALL increment by 1 on every clock with halt=0 and wrap from all-ones to 0.
REQ-031 instret SHALL increment by 1 on every clock with instr_retire=1 and wrap from all-ones to 0.
REQ-032 The counters SHALL be read as their value at the READ cycle edge.
REQ-033 With CNT_EN=0, addresses 12'hC00 and 12'hC02 SHALL be unimplemented.
REQ-034 Only one request SHALL be in flight; req_valid outside IDLE SHALL be ignored.

Reset
REQ-035 rst_n=0 SHALL immediately, asynchronously:
- force the FSM to IDLE;
- set all scratch CSRs and both counters to 0;
- set rsp_valid=0, rsp_rdata=0 and rsp_illegal=0.
REQ-036 Reset asserted during READ or WRITE SHALL abort the request with no write and no response.
REQ-037 req_ready SHALL be 1 in the first cycle after rst_n deasserts, provided halt=0.

Verification
REQ-038 CSRRW to 12'h340 with rs1_data=32'hA5A5_0001 -> rsp_rdata=0 two cycles later; a following CSRRS with src_idx=0 -> rsp_rdata=32'hA5A5_0001 and the value is unchanged.
REQ-039 Scratch CSR 12'h341 holds 32'hFF; CSRRCI with uimm=5'h0F -> rsp_rdata=32'hFF and the new value is 32'hF0; then CSRRSI with uimm=0 -> no write.
REQ-040 CSRRW to 12'hC00 -> rsp_illegal=1, rsp_rdata=0 and the counter is unaffected; CSRRS with src_idx=0 to 12'hC00 -> legal, and the value equals the clocks since reset excluding halt cycles.
REQ-041 Request to 12'h7FF, and separately funct3=100 -> rsp_illegal=1 and no state change.
REQ-042 halt=1 held for 3 cycles while in READ -> rsp_valid is delayed by exactly 3 cycles, the cycle counter is frozen and the data is correct.
REQ-043 rst_n pulsed low while in WRITE of a CSRRW -> no rsp_valid, the target CSR reads 0, and req_ready=1 after release.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// ============================================================================
// Module   : csr_access_ctrl
// Brief    : CSR instruction sequencer (IDLE/READ/WRITE) with scratch CSRs
//            and optional read-only cycle/instret counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_access_ctrl #(
    parameter int          XLEN      = 32,
    parameter int          NUM_CSR   = 8,
    parameter logic [11:0] BASE_ADDR = 12'h340,
    parameter bit          CNT_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      src_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            instr_retire,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [11:0] c_cycle_addr   = 12'hC00;
    localparam logic [11:0] c_instret_addr = 12'hC02;

    state_t            r_state;
    logic [2:0]        r_funct3;
    logic [11:0]       r_addr;
    logic [4:0]        r_src;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_old;
    logic [XLEN-1:0]   r_new;
    logic              r_wr_en;
    logic              r_illegal;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_illegal;
    logic [XLEN-1:0]   r_csr [NUM_CSR];

    logic [XLEN-1:0]   w_cycle;
    logic [XLEN-1:0]   w_instret;
    logic [XLEN-1:0]   w_old;
    logic [XLEN-1:0]   w_new;
    logic [XLEN-1:0]   w_operand;
    logic              w_impl;
    logic              w_wen;
    logic              w_illegal;
    logic              w_wr_fire;

    assign req_ready   = (r_state == IDLE) && !halt;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_illegal = r_rsp_illegal;

    if (CNT_EN) begin : g_cnt
        logic [XLEN-1:0] r_cycle;
        logic [XLEN-1:0] r_instret;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cycle   <= '0;
                r_instret <= '0;
            end else begin
                if (!halt)
                    r_cycle <= r_cycle + XLEN'(1);
                if (instr_retire)
                    r_instret <= r_instret + XLEN'(1);
            end
        end

        assign w_cycle   = r_cycle;
        assign w_instret = r_instret;
    end else begin : g_no_cnt
        assign w_cycle   = '0;
        assign w_instret = '0;
    end

    // Address decode and old-value mux on the latched request.
    always_comb begin
        w_old  = '0;
        w_impl = 1'b0;
        for (int i = 0; i < NUM_CSR; i++) begin
            if (r_addr == (BASE_ADDR + 12'(i))) begin
                w_old  = r_csr[i];
                w_impl = 1'b1;
            end
        end
        if (CNT_EN && (r_addr == c_cycle_addr)) begin
            w_old  = w_cycle;
            w_impl = 1'b1;
        end
        if (CNT_EN && (r_addr == c_instret_addr)) begin
            w_old  = w_instret;
            w_impl = 1'b1;
        end
    end

    always_comb begin
        w_operand = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_src} : r_rs1;
        // Set/clear forms with a zero source are pure reads.
        w_wen     = (r_funct3[1:0] == 2'b01) || (r_src != 5'd0);
        w_illegal = (r_funct3[1:0] == 2'b00) || !w_impl
                    || (w_wen && (r_addr[11:10] == 2'b11));
        case (r_funct3[1:0])
            2'b01:   w_new = w_operand;
            2'b10:   w_new = w_old | w_operand;
            2'b11:   w_new = w_old & ~w_operand;
            default: w_new = w_old;
        endcase
    end

    assign w_wr_fire = (r_state == WRITE) && !halt && r_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_funct3      <= 3'd0;
            r_addr        <= 12'd0;
            r_src         <= 5'd0;
            r_rs1         <= '0;
            r_old         <= '0;
            r_new         <= '0;
            r_wr_en       <= 1'b0;
            r_illegal     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_illegal <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_funct3 <= funct3;
                        r_addr   <= csr_addr;
                        r_src    <= src_idx;
                        r_rs1    <= rs1_data;
                        r_state  <= READ;
                    end
                end
                READ: begin
                    if (!halt) begin
                        r_old     <= w_old;
                        r_new     <= w_new;
                        r_wr_en   <= w_wen && !w_illegal;
                        r_illegal <= w_illegal;
                        r_state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (!halt) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_illegal ? '0 : r_old;
                        r_rsp_illegal <= r_illegal;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CSR; i++)
                r_csr[i] <= '0;
        end else if (w_wr_fire) begin
            for (int i = 0; i < NUM_CSR; i++)
                if (r_addr == (BASE_ADDR + 12'(i)))
                    r_csr[i] <= r_new;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
// ============================================================================
// Module   : tb_csr_access_ctrl
// Brief    : Directed self-checking bench for csr_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  src_idx;
    logic [31:0] rs1_data;
    logic        instr_retire;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    int          n_pass;
    int          n_fail;
    int          n_total;
    logic [31:0] exp_cyc;
    logic [31:0] exp_ret;

    csr_access_ctrl #(
        .XLEN      (32),
        .NUM_CSR   (8),
        .BASE_ADDR (12'h340),
        .CNT_EN    (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt         (halt),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .funct3       (funct3),
        .csr_addr     (csr_addr),
        .src_idx      (src_idx),
        .rs1_data     (rs1_data),
        .instr_retire (instr_retire),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_illegal  (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference counters: clocks out of reset without halt, and retirements.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cyc <= 32'd0;
            exp_ret <= 32'd0;
        end else begin
            if (!halt)
                exp_cyc <= exp_cyc + 32'd1;
            if (instr_retire)
                exp_ret <= exp_ret + 32'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] s,
                          input logic [31:0] d, input int hc,
                          output logic [31:0] rd, output logic il, output int lat,
                          output logic [31:0] snap_c, output logic [31:0] snap_r);
        check("req_ready before accept", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        funct3    = f3;
        csr_addr  = a;
        src_idx   = s;
        rs1_data  = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        snap_c    = exp_cyc;
        snap_r    = exp_ret;
        if (hc > 0) halt = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (hc > 0 && lat == hc) halt = 1'b0;
        end while (!rsp_valid && lat < 20);
        rd = rsp_rdata;
        il = rsp_illegal;
        @(posedge clk); #1;
        check("rsp_valid one-shot", {31'b0, rsp_valid}, 32'd0);
    endtask

    task automatic req_chk(input string tag, input logic [2:0] f3, input logic [11:0] a,
                           input logic [4:0] s, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_il);
        logic [31:0] rd, sc, sr;
        logic        il;
        int          lat;
        do_req(f3, a, s, d, 0, rd, il, lat, sc, sr);
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " illegal"}, {31'b0, il}, {31'b0, exp_il});
    endtask

    initial begin
        logic [31:0] rd, sc, sr;
        logic        il;
        int          lat;
        bit          seen;

        n_pass = 0; n_fail = 0; n_total = 0;
        rst_n = 1'b0; halt = 1'b0; req_valid = 1'b0; funct3 = 3'd0;
        csr_addr = 12'd0; src_idx = 5'd0; rs1_data = 32'd0; instr_retire = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
        rst_n = 1'b1;
        check("req_ready after reset", {31'b0, req_ready}, 32'd1);

        // Register forms on scratch 0x340
        req_chk("rw 340", 3'b001, 12'h340, 5'd1, 32'hA5A5_0001, 32'h0, 1'b0);
        req_chk("rs0 340", 3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'hA5A5_0001, 1'b0);
        req_chk("rs0 340 again", 3'b010, 12'h340, 5'd0, 32'h0, 32'hA5A5_0001, 1'b0);

        // Immediate and set/clear forms on 0x341 / 0x342
        req_chk("rw 341", 3'b001, 12'h341, 5'd2, 32'h0000_00FF, 32'h0, 1'b0);
        req_chk("rci 341", 3'b111, 12'h341, 5'h0F, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b0);
        req_chk("rsi0 341", 3'b110, 12'h341, 5'd0, 32'hFFFF_FFFF, 32'h0000_00F0, 1'b0);
        req_chk("rs 341", 3'b010, 12'h341, 5'd5, 32'h0000_0F00, 32'h0000_00F0, 1'b0);
        req_chk("rc 341", 3'b011, 12'h341, 5'd3, 32'h0000_00F0, 32'h0000_0FF0, 1'b0);
        req_chk("read 341", 3'b010, 12'h341, 5'd0, 32'h0, 32'h0000_0F00, 1'b0);
        req_chk("rwi 342", 3'b101, 12'h342, 5'h1F, 32'hFFFF_0000, 32'h0, 1'b0);
        req_chk("rsi 342", 3'b110, 12'h342, 5'h01, 32'hFFFF_FFFF, 32'h0000_001F, 1'b0);
        req_chk("read 342", 3'b010, 12'h342, 5'd0, 32'h0, 32'h0000_001F, 1'b0);

        // Address range edges
        req_chk("read 347", 3'b010, 12'h347, 5'd0, 32'h0, 32'h0, 1'b0);
        req_chk("read 348", 3'b010, 12'h348, 5'd0, 32'h0, 32'h0, 1'b1);
        req_chk("read 33f", 3'b010, 12'h33F, 5'd0, 32'h0, 32'h0, 1'b1);

        // Counters: write is illegal, pure read is legal
        req_chk("rw c00", 3'b001, 12'hC00, 5'd1, 32'h0000_0123, 32'h0, 1'b1);
        req_chk("rs1 c00", 3'b010, 12'hC00, 5'd1, 32'h0, 32'h0, 1'b1);
        do_req(3'b010, 12'hC00, 5'd0, 32'h0, 0, rd, il, lat, sc, sr);
        check("cycle latency", 32'(lat), 32'd2);
        check("cycle value", rd, sc);
        check("cycle illegal", {31'b0, il}, 32'd0);

        instr_retire = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        instr_retire = 1'b0;
        do_req(3'b010, 12'hC02, 5'd0, 32'h0, 0, rd, il, lat, sc, sr);
        check("instret value", rd, sr);
        check("instret nonzero", 32'(rd != 32'd0), 32'd1);
        check("instret illegal", {31'b0, il}, 32'd0);

        // Illegal accesses leave state untouched
        req_chk("read 7ff", 3'b010, 12'h7FF, 5'd0, 32'h0, 32'h0, 1'b1);
        req_chk("f3 100", 3'b100, 12'h340, 5'd7, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req_chk("f3 000", 3'b000, 12'h340, 5'd7, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req_chk("340 kept", 3'b010, 12'h340, 5'd0, 32'h0, 32'hA5A5_0001, 1'b0);

        // Halt for 3 cycles in READ: delayed response, frozen cycle counter
        do_req(3'b010, 12'hC00, 5'd0, 32'h0, 3, rd, il, lat, sc, sr);
        check("halt latency", 32'(lat), 32'd5);
        check("halt cycle value", rd, sc);
        check("halt illegal", {31'b0, il}, 32'd0);

        // Halt in IDLE blocks acceptance
        halt = 1'b1;
        req_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h344; src_idx = 5'd1;
        rs1_data = 32'h1234_5678;
        #1;
        check("req_ready halted", {31'b0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        halt = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no accept while halted", {31'b0, seen}, 32'd0);
        req_chk("344 untouched", 3'b010, 12'h344, 5'd0, 32'h0, 32'h0, 1'b0);

        // Reset asserted during WRITE aborts the request
        req_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h343; src_idx = 5'd1;
        rs1_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort no response", {31'b0, seen}, 32'd0);
        rst_n = 1'b1;
        check("req_ready after abort", {31'b0, req_ready}, 32'd1);
        req_chk("343 after abort", 3'b010, 12'h343, 5'd0, 32'h0, 32'h0, 1'b0);
        req_chk("340 after reset", 3'b010, 12'h340, 5'd0, 32'h0, 32'h0, 1'b0);
        do_req(3'b010, 12'hC00, 5'd0, 32'h0, 0, rd, il, lat, sc, sr);
        check("cycle after reset", rd, sc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
